// File: rtl/uart_tx_ctrl_if.sv
// FIFO read-port bundle between the UART TX FIFO and the transmit controller.
// The controller is the master: it owns the pop strobe and consumes empty/rdata.
interface uart_tx_ctrl_if;
    logic       i_riscv_uart_fifo_empty;
    logic [7:0] i_riscv_uart_fifo_rdata;
    logic       o_riscv_uart_fifo_rinc;

    modport master (
        input  i_riscv_uart_fifo_empty,
        input  i_riscv_uart_fifo_rdata,
        output o_riscv_uart_fifo_rinc
    );

    modport slave (
        output i_riscv_uart_fifo_empty,
        output i_riscv_uart_fifo_rdata,
        input  o_riscv_uart_fifo_rinc
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: pops bytes from the TX FIFO and serializes them as
// start + 8 data (LSB first) + optional parity + 1/2 stop bits.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | line high, waiting for tx_en and a non-empty FIFO
// START  | start bit (line low) for one bit period
// DATA   | 8 data bits from the shift register, LSB first
// PARITY | latched parity bit for one bit period
// STOP   | line high for one or two bit periods; last cycle may pop
module uart_tx_ctrl #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 i_riscv_uart_clk,
    input  logic                 i_riscv_uart_rst,
    input  logic                 i_riscv_uart_tx_en,
    input  logic [DIV_WIDTH-1:0] i_riscv_uart_baud_div,
    input  logic                 i_riscv_uart_parity_en,
    input  logic                 i_riscv_uart_parity_odd,
    input  logic                 i_riscv_uart_stop2,
    uart_tx_ctrl_if.master       fifo,
    output logic                 o_riscv_uart_tx,
    output logic                 o_riscv_uart_busy,
    output logic                 o_riscv_uart_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    logic [7:0]           shift;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] timer;
    logic [DIV_WIDTH-1:0] div_in;
    logic [DIV_WIDTH-1:0] reload;
    logic                 par_en_q;
    logic                 par_bit_q;
    logic                 stop2_q;
    logic                 stop_second;
    logic [2:0]           bit_cnt;
    logic                 bit_end;
    logic                 last_stop;
    logic                 pop;

    assign div_in    = (i_riscv_uart_baud_div == '0) ? DIV_WIDTH'(1) : i_riscv_uart_baud_div;
    assign reload    = div_q - DIV_WIDTH'(1);
    assign bit_end   = (timer == '0);
    assign last_stop = (state == S_STOP) && bit_end && !stop_second;

    // Pop is combinational so rdata is sampled in the same cycle rinc is high;
    // gating with reset keeps the FIFO untouched while the frame is abandoned.
    assign pop = !i_riscv_uart_rst && ((state == S_IDLE) || last_stop) &&
                 i_riscv_uart_tx_en && !fifo.i_riscv_uart_fifo_empty;
    assign fifo.o_riscv_uart_fifo_rinc = pop;

    always_ff @(posedge i_riscv_uart_clk or posedge i_riscv_uart_rst) begin
        if (i_riscv_uart_rst) begin
            state             <= S_IDLE;
            shift             <= '0;
            div_q             <= DIV_WIDTH'(1);
            timer             <= '0;
            par_en_q          <= 1'b0;
            par_bit_q         <= 1'b0;
            stop2_q           <= 1'b0;
            stop_second       <= 1'b0;
            bit_cnt           <= '0;
            o_riscv_uart_tx   <= 1'b1;
            o_riscv_uart_busy <= 1'b0;
            o_riscv_uart_done <= 1'b0;
        end else begin
            o_riscv_uart_done <= 1'b0;
            if (pop) begin
                shift             <= fifo.i_riscv_uart_fifo_rdata;
                div_q             <= div_in;
                par_en_q          <= i_riscv_uart_parity_en;
                par_bit_q         <= (^fifo.i_riscv_uart_fifo_rdata) ^ i_riscv_uart_parity_odd;
                stop2_q           <= i_riscv_uart_stop2;
                timer             <= div_in - DIV_WIDTH'(1);
                bit_cnt           <= '0;
                stop_second       <= 1'b0;
                state             <= S_START;
                o_riscv_uart_tx   <= 1'b0;
                o_riscv_uart_busy <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        o_riscv_uart_tx   <= 1'b1;
                        o_riscv_uart_busy <= 1'b0;
                    end
                    S_START: begin
                        if (bit_end) begin
                            state           <= S_DATA;
                            o_riscv_uart_tx <= shift[0];
                            timer           <= reload;
                            bit_cnt         <= '0;
                        end else begin
                            timer <= timer - DIV_WIDTH'(1);
                        end
                    end
                    S_DATA: begin
                        if (bit_end) begin
                            timer <= reload;
                            if (bit_cnt == 3'd7) begin
                                if (par_en_q) begin
                                    state           <= S_PARITY;
                                    o_riscv_uart_tx <= par_bit_q;
                                end else begin
                                    state             <= S_STOP;
                                    o_riscv_uart_tx   <= 1'b1;
                                    stop_second       <= stop2_q;
                                    o_riscv_uart_done <= (reload == '0) && !stop2_q;
                                end
                            end else begin
                                shift           <= {1'b0, shift[7:1]};
                                o_riscv_uart_tx <= shift[1];
                                bit_cnt         <= bit_cnt + 3'd1;
                            end
                        end else begin
                            timer <= timer - DIV_WIDTH'(1);
                        end
                    end
                    S_PARITY: begin
                        if (bit_end) begin
                            state             <= S_STOP;
                            timer             <= reload;
                            o_riscv_uart_tx   <= 1'b1;
                            stop_second       <= stop2_q;
                            o_riscv_uart_done <= (reload == '0) && !stop2_q;
                        end else begin
                            timer <= timer - DIV_WIDTH'(1);
                        end
                    end
                    S_STOP: begin
                        // done is registered, so it is raised one cycle ahead of
                        // the cycle in which the final stop bit ends.
                        if (bit_end) begin
                            if (stop_second) begin
                                stop_second       <= 1'b0;
                                timer             <= reload;
                                o_riscv_uart_done <= (reload == '0);
                            end else begin
                                state             <= S_IDLE;
                                o_riscv_uart_tx   <= 1'b1;
                                o_riscv_uart_busy <= 1'b0;
                            end
                        end else begin
                            timer             <= timer - DIV_WIDTH'(1);
                            o_riscv_uart_done <= (timer == DIV_WIDTH'(1)) && !stop_second;
                        end
                    end
                    default: begin
                        state             <= S_IDLE;
                        o_riscv_uart_tx   <= 1'b1;
                        o_riscv_uart_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: a frame-level model predicts every output cycle by cycle,
// and directed scenarios pin the model with hand-computed values.
module tb_uart_tx_ctrl;

    logic        clk;
    logic        rst;
    logic        tx_en;
    logic [15:0] baud_div;
    logic        parity_en;
    logic        parity_odd;
    logic        stop2;
    logic        tx;
    logic        busy;
    logic        done;

    uart_tx_ctrl_if fifo_bus ();

    uart_tx_ctrl #(.DIV_WIDTH(16)) dut (
        .i_riscv_uart_clk        (clk),
        .i_riscv_uart_rst        (rst),
        .i_riscv_uart_tx_en      (tx_en),
        .i_riscv_uart_baud_div   (baud_div),
        .i_riscv_uart_parity_en  (parity_en),
        .i_riscv_uart_parity_odd (parity_odd),
        .i_riscv_uart_stop2      (stop2),
        .fifo                    (fifo_bus),
        .o_riscv_uart_tx         (tx),
        .o_riscv_uart_busy       (busy),
        .o_riscv_uart_done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] fifo_q[$];
    bit         line_q[$];
    bit         pop_pend = 1'b0;

    logic tx_r   [0:255];
    logic busy_r [0:255];
    logic done_r [0:255];
    logic rinc_r [0:255];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fifo_update();
        fifo_bus.i_riscv_uart_fifo_empty = (fifo_q.size() == 0);
        fifo_bus.i_riscv_uart_fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        fifo_update();
    endtask

    // Model: a frame is the list of line levels, each held max(div,1) cycles.
    task automatic model_frame(input logic [7:0] d);
        int  n;
        bit  bits[$];
        n = (baud_div == 16'd0) ? 1 : int'(baud_div);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (parity_en) bits.push_back((^d) ^ parity_odd);
        bits.push_back(1'b1);
        if (stop2) bits.push_back(1'b1);
        foreach (bits[k]) for (int j = 0; j < n; j++) line_q.push_back(bits[k]);
    endtask

    always @(negedge clk) begin
        bit exp_pop;
        if (rst) begin
            line_q.delete();
            chk("rst_tx", tx, 1);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_rinc", fifo_bus.o_riscv_uart_fifo_rinc, 0);
            pop_pend = 1'b0;
        end else begin
            exp_pop = (line_q.size() <= 1) && tx_en && (fifo_q.size() != 0);
            chk("model_tx", tx, (line_q.size() != 0) ? line_q[0] : 1'b1);
            chk("model_busy", busy, line_q.size() != 0);
            chk("model_done", done, line_q.size() == 1);
            chk("model_rinc", fifo_bus.o_riscv_uart_fifo_rinc, exp_pop);
            if (line_q.size() != 0) void'(line_q.pop_front());
            if (exp_pop) model_frame(fifo_q[0]);
            pop_pend = fifo_bus.o_riscv_uart_fifo_rinc;
        end
    end

    // FIFO behaviour: the head leaves right after the edge where rinc was high.
    always @(posedge clk) begin
        #1;
        if (pop_pend && fifo_q.size() != 0) void'(fifo_q.pop_front());
        fifo_update();
    end

    task automatic wait_rinc(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = fifo_bus.o_riscv_uart_fifo_rinc;
        end
        chk(name, seen, 1);
    endtask

    // Index 0 is the current negedge; each further index is one cycle later.
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            tx_r[i]   = tx;
            busy_r[i] = busy;
            done_r[i] = done;
            rinc_r[i] = fifo_bus.o_riscv_uart_fifo_rinc;
        end
    endtask

    function automatic int count(input int which, input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) begin
            case (which)
                0: c += int'(tx_r[i] === 1'b1);
                1: c += int'(busy_r[i] === 1'b1);
                2: c += int'(done_r[i] === 1'b1);
                default: c += int'(rinc_r[i] === 1'b1);
            endcase
        end
        return c;
    endfunction

    task automatic setup(input logic [15:0] div, input logic pe, input logic po, input logic s2);
        @(posedge clk);
        #1;
        baud_div   = div;
        parity_en  = pe;
        parity_odd = po;
        stop2      = s2;
        tx_en      = 1'b1;
    endtask

    int pat[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    initial begin
        rst        = 1'b0;
        tx_en      = 1'b0;
        baud_div   = 16'd4;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        stop2      = 1'b0;
        fifo_update();

        // Reset with random inputs, then 100 quiet cycles with the FIFO empty.
        #2;
        rst        = 1'b1;
        tx_en      = 1'($urandom_range(0, 1));
        baud_div   = 16'($urandom);
        parity_en  = 1'($urandom_range(0, 1));
        stop2      = 1'($urandom_range(0, 1));
        push(8'($urandom));
        #1;
        chk("reset_tx", tx, 1);
        chk("reset_rinc", fifo_bus.o_riscv_uart_fifo_rinc, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        repeat (3) @(posedge clk);
        #1;
        fifo_q.delete();
        fifo_update();
        tx_en = 1'b1;
        rst   = 1'b0;
        @(negedge clk);
        capture(100);
        chk("quiet_tx_high", count(0, 0, 99), 100);
        chk("quiet_busy", count(1, 0, 99), 0);
        chk("quiet_rinc", count(3, 0, 99), 0);

        // 0xA5, div 4, no parity, one stop.
        setup(16'd4, 1'b0, 1'b0, 1'b0);
        push(8'hA5);
        wait_rinc("a5_rinc_seen");
        capture(45);
        for (int c = 1; c <= 40; c++) chk("a5_tx_level", tx_r[c], pat[(c - 1) / 4]);
        chk("a5_done_40", done_r[40], 1);
        chk("a5_done_count", count(2, 0, 44), 1);
        chk("a5_busy_41", busy_r[41], 0);
        chk("a5_rinc_count", count(3, 0, 44), 1);

        // 0x07, even parity, two stops, div 2, then odd parity.
        setup(16'd2, 1'b1, 1'b0, 1'b1);
        push(8'h07);
        wait_rinc("p07e_rinc_seen");
        capture(28);
        chk("p07e_bit7", tx_r[17], 0);
        chk("p07e_parity", tx_r[19], 1);
        chk("p07e_stop", count(0, 21, 24), 4);
        chk("p07e_done_23", done_r[23], 0);
        chk("p07e_done_24", done_r[24], 1);
        chk("p07e_busy_24", busy_r[24], 1);
        chk("p07e_busy_25", busy_r[25], 0);
        setup(16'd2, 1'b1, 1'b1, 1'b1);
        push(8'h07);
        wait_rinc("p07o_rinc_seen");
        capture(28);
        chk("p07o_parity", tx_r[19], 0);
        chk("p07o_done_24", done_r[24], 1);

        // Three queued bytes, div 3: frames chained with no idle gap.
        setup(16'd3, 1'b0, 1'b0, 1'b0);
        push(8'h3C);
        push(8'hFF);
        push(8'h00);
        wait_rinc("b2b_rinc_seen");
        capture(96);
        chk("b2b_rinc_30", rinc_r[30], 1);
        chk("b2b_rinc_60", rinc_r[60], 1);
        chk("b2b_rinc_count", count(3, 0, 95), 3);
        chk("b2b_stop_30", tx_r[30], 1);
        chk("b2b_start_31", tx_r[31], 0);
        chk("b2b_busy_span", count(1, 1, 90), 90);
        chk("b2b_busy_91", busy_r[91], 0);
        chk("b2b_done_90", done_r[90], 1);

        // tx_en dropped during DATA with two bytes queued.
        setup(16'd2, 1'b0, 1'b0, 1'b0);
        push(8'h55);
        push(8'h81);
        wait_rinc("en_rinc_seen");
        fork
            capture(50);
            begin
                repeat (8) @(posedge clk);
                #1;
                tx_en = 1'b0;
            end
        join
        chk("en_done_20", done_r[20], 1);
        chk("en_busy_21", busy_r[21], 0);
        chk("en_rinc_count", count(3, 0, 49), 1);
        chk("en_fifo_left", fifo_q.size(), 1);
        @(posedge clk);
        #1;
        tx_en = 1'b1;
        wait_rinc("en_resume_rinc");
        repeat (25) @(negedge clk);

        // Reset during PARITY: line high at once, FIFO not popped.
        setup(16'd2, 1'b1, 1'b0, 1'b0);
        push(8'h12);
        push(8'h34);
        wait_rinc("rp_rinc_seen");
        capture(20);
        chk("rp_parity", tx_r[19], 0);
        #1;
        rst = 1'b1;
        #1;
        chk("rp_tx", tx, 1);
        chk("rp_busy", busy, 0);
        chk("rp_rinc", fifo_bus.o_riscv_uart_fifo_rinc, 0);
        repeat (3) @(posedge clk);
        chk("rp_fifo_left", fifo_q.size(), 1);
        #1;
        fifo_q.delete();
        fifo_update();
        rst = 1'b0;

        // Divisor 0 behaves as 1.
        setup(16'd0, 1'b0, 1'b0, 1'b0);
        push(8'h5A);
        wait_rinc("d0_rinc_seen");
        capture(14);
        chk("d0_start", tx_r[1], 0);
        chk("d0_bit0", tx_r[2], 0);
        chk("d0_bit1", tx_r[3], 1);
        chk("d0_stop", tx_r[10], 1);
        chk("d0_done_10", done_r[10], 1);
        chk("d0_busy_11", busy_r[11], 0);

        // Divisor changed mid-frame only affects the next frame.
        setup(16'd4, 1'b0, 1'b0, 1'b0);
        push(8'hC3);
        push(8'h97);
        wait_rinc("dv_rinc_seen");
        fork
            capture(125);
            begin
                repeat (5) @(posedge clk);
                #1;
                baud_div = 16'd8;
            end
        join
        chk("dv_bit0", count(0, 5, 8), 4);
        chk("dv_done_40", done_r[40], 1);
        chk("dv_rinc_40", rinc_r[40], 1);
        chk("dv_start2_48", tx_r[48], 0);
        chk("dv_bit0_49", tx_r[49], 1);
        chk("dv_done_120", done_r[120], 1);
        chk("dv_done_count", count(2, 0, 124), 2);
        chk("dv_busy_121", busy_r[121], 0);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
